// File: rtl/cache_pkg.sv
// cache_pkg: geometry, op encoding and request record shared by the request front end and the cache core.
package cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int BYTE_BITS  = 6;
    localparam int INDEX_BITS = 14;
    localparam int TAG_BITS   = ADDR_W - INDEX_BITS - BYTE_BITS;
    localparam int NUM_SETS   = 1 << INDEX_BITS;

    typedef enum logic [3:0] {
        OP_RD_D     = 4'd0,
        OP_WR_D     = 4'd1,
        OP_RD_I     = 4'd2,
        OP_SNP_INV  = 4'd3,
        OP_SNP_RD   = 4'd4,
        OP_SNP_WR   = 4'd5,
        OP_SNP_RWIM = 4'd6,
        OP_CLR      = 4'd8,
        OP_PRINT    = 4'd9
    } op_e;

    typedef struct packed {
        op_e                   op;
        logic [TAG_BITS-1:0]   tag;
        logic [INDEX_BITS-1:0] index;
        logic [BYTE_BITS-1:0]  offset;
        logic                  snoop;
        logic                  last;
    } req_t;

    function automatic logic is_snoop(input logic [3:0] n);
        return (n >= 4'd3) && (n <= 4'd6);
    endfunction

    function automatic logic is_access(input logic [3:0] n);
        return n <= 4'd6;
    endfunction

    function automatic logic is_sweep(input logic [3:0] n);
        return (n == OP_CLR) || (n == OP_PRINT);
    endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// cache_req_fifo: small synchronous FIFO holding raw {n, addr} trace commands; non-bypassing.
`default_nettype none

module cache_req_fifo #(
    parameter int DW    = 36,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          w_do_push;
    logic          w_do_pop;

    // Extra pointer bit separates full from empty when the address bits match.
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o   = (wr_q == rd_q);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (w_do_push) wr_q <= wr_q + 1'b1;
            if (w_do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/cache_req_frontend.sv
// cache_req_frontend: buffers trace commands, drops illegal codes, expands clear/print into per-set sweeps.
// Optional per-class accepted-op counters are built when CACHE_FE_STATS_EN is defined.
`default_nettype none

module cache_req_frontend #(
    parameter int ADDR_W     = cache_pkg::ADDR_W,
    parameter int BYTE_BITS  = cache_pkg::BYTE_BITS,
    parameter int INDEX_BITS = cache_pkg::INDEX_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic                                 trc_valid,
    output logic                                 trc_ready,
    input  logic [3:0]                           trc_n,
    input  logic [ADDR_W-1:0]                    trc_addr,
    output logic                                 req_valid,
    input  logic                                 req_ready,
    output logic [3:0]                           req_op,
    output logic [ADDR_W-INDEX_BITS-BYTE_BITS-1:0] req_tag,
    output logic [INDEX_BITS-1:0]                req_index,
    output logic [BYTE_BITS-1:0]                 req_offset,
    output logic                                 req_snoop,
    output logic                                 req_last,
    output logic                                 busy,
    output logic [15:0]                          illegal_cnt
`ifdef CACHE_FE_STATS_EN
    ,
    output logic [31:0]                          rd_cnt,
    output logic [31:0]                          wr_cnt,
    output logic [31:0]                          ifetch_cnt,
    output logic [31:0]                          snoop_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_BITS - BYTE_BITS;
    localparam int FW    = 4 + ADDR_W;

    typedef enum logic [0:0] {
        ST_PASS  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e                  state_q;
    logic [INDEX_BITS-1:0]   cnt_q;
    logic [3:0]              sweep_op_q;
    logic                    valid_q;
    logic [3:0]              op_q;
    logic [TAG_W-1:0]        tag_q;
    logic [INDEX_BITS-1:0]   index_q;
    logic [BYTE_BITS-1:0]    offset_q;
    logic                    snoop_q;
    logic                    last_q;
    logic [15:0]             illegal_q;

    logic [FW-1:0]           w_head;
    logic [3:0]              w_head_n;
    logic [ADDR_W-1:0]       w_head_addr;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load_ok;
    logic                    w_cnt_last;

    assign trc_ready   = !w_full;
    assign w_push      = trc_valid && trc_ready;
    assign w_load_ok   = !valid_q || req_ready;
    assign w_pop       = (state_q == ST_PASS) && !w_empty && w_load_ok;
    assign w_head_n    = w_head[FW-1 -: 4];
    assign w_head_addr = w_head[ADDR_W-1:0];
    assign w_cnt_last  = &cnt_q;

    cache_req_fifo #(
        .DW    (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (w_push),
        .din_i   ({trc_n, trc_addr}),
        .pop_i   (w_pop),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_PASS;
            cnt_q      <= '0;
            sweep_op_q <= '0;
            valid_q    <= 1'b0;
            op_q       <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            offset_q   <= '0;
            snoop_q    <= 1'b0;
            last_q     <= 1'b0;
            illegal_q  <= '0;
        end else begin
            // A loadable stage with nothing new to load goes empty this cycle.
            if (w_load_ok) valid_q <= 1'b0;
            case (state_q)
                ST_PASS: begin
                    if (w_pop) begin
                        if (cache_pkg::is_access(w_head_n)) begin
                            valid_q  <= 1'b1;
                            op_q     <= w_head_n;
                            tag_q    <= w_head_addr[ADDR_W-1 -: TAG_W];
                            index_q  <= w_head_addr[BYTE_BITS +: INDEX_BITS];
                            offset_q <= w_head_addr[BYTE_BITS-1:0];
                            snoop_q  <= cache_pkg::is_snoop(w_head_n);
                            last_q   <= 1'b0;
                        end else if (cache_pkg::is_sweep(w_head_n)) begin
                            sweep_op_q <= w_head_n;
                            cnt_q      <= '0;
                            state_q    <= ST_SWEEP;
                        end else if (illegal_q != 16'hFFFF) begin
                            illegal_q <= illegal_q + 16'd1;
                        end
                    end
                end
                ST_SWEEP: begin
                    if (w_load_ok) begin
                        valid_q  <= 1'b1;
                        op_q     <= sweep_op_q;
                        tag_q    <= '0;
                        index_q  <= cnt_q;
                        offset_q <= '0;
                        snoop_q  <= 1'b0;
                        last_q   <= w_cnt_last;
                        if (w_cnt_last) state_q <= ST_PASS;
                        else            cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_PASS;
            endcase
        end
    end

    assign req_valid   = valid_q;
    assign req_op      = op_q;
    assign req_tag     = tag_q;
    assign req_index   = index_q;
    assign req_offset  = offset_q;
    assign req_snoop   = snoop_q;
    assign req_last    = last_q;
    assign illegal_cnt = illegal_q;
    assign busy        = !w_empty || valid_q || (state_q == ST_SWEEP);

`ifdef CACHE_FE_STATS_EN
    // Sweep ops carry codes 8/9, so decoding the held op code excludes them.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            ifetch_cnt <= '0;
            snoop_cnt  <= '0;
        end else if (valid_q && req_ready) begin
            if (op_q == 4'd0) rd_cnt     <= rd_cnt + 32'd1;
            if (op_q == 4'd1) wr_cnt     <= wr_cnt + 32'd1;
            if (op_q == 4'd2) ifetch_cnt <= ifetch_cnt + 32'd1;
            if (cache_pkg::is_snoop(op_q)) snoop_cnt <= snoop_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_req_frontend.sv
// tb_cache_req_frontend: directed stimulus against a queue-based expected-op model, plus literal checks.
`default_nettype none

module tb_cache_req_frontend;

    localparam int ADDR_W     = 32;
    localparam int BYTE_BITS  = 6;
    localparam int INDEX_BITS = 14;
    localparam int TAG_W      = ADDR_W - INDEX_BITS - BYTE_BITS;
    localparam int NUM_SETS   = 1 << INDEX_BITS;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              trc_valid = 1'b0;
    logic              trc_ready;
    logic [3:0]        trc_n = '0;
    logic [ADDR_W-1:0] trc_addr = '0;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [3:0]        req_op;
    logic [TAG_W-1:0]  req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [BYTE_BITS-1:0]  req_offset;
    logic              req_snoop;
    logic              req_last;
    logic              busy;
    logic [15:0]       illegal_cnt;
`ifdef CACHE_FE_STATS_EN
    logic [31:0]       rd_cnt, wr_cnt, ifetch_cnt, snoop_cnt;
`endif

    cache_req_frontend dut (
        .clk         (clk),
        .rstb        (rstb),
        .trc_valid   (trc_valid),
        .trc_ready   (trc_ready),
        .trc_n       (trc_n),
        .trc_addr    (trc_addr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .req_index   (req_index),
        .req_offset  (req_offset),
        .req_snoop   (req_snoop),
        .req_last    (req_last),
        .busy        (busy),
        .illegal_cnt (illegal_cnt)
`ifdef CACHE_FE_STATS_EN
        ,
        .rd_cnt      (rd_cnt),
        .wr_cnt      (wr_cnt),
        .ifetch_cnt  (ifetch_cnt),
        .snoop_cnt   (snoop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned op;
        int unsigned tag;
        int unsigned index;
        int unsigned offset;
        int unsigned snoop;
        int unsigned last;
    } exp_t;

    exp_t        exp_q[$];
    int          exp_illegal = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          last_cnt = 0;
    int unsigned last_op = 0, last_index = 0, last_snoop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: what the cache core must see, derived from each accepted trace command.
    task automatic model_push(input int unsigned n, input int unsigned addr);
        exp_t e;
        if (n <= 6) begin
            e.op     = n;
            e.tag    = addr >> (INDEX_BITS + BYTE_BITS);
            e.index  = (addr >> BYTE_BITS) % NUM_SETS;
            e.offset = addr % (1 << BYTE_BITS);
            e.snoop  = (n >= 3 && n <= 6) ? 1 : 0;
            e.last   = 0;
            exp_q.push_back(e);
        end else if (n == 8 || n == 9) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                e.op = n; e.tag = 0; e.index = i; e.offset = 0; e.snoop = 0;
                e.last = (i == NUM_SETS - 1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end else if (exp_illegal < 16'hFFFF) begin
            exp_illegal++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstb) begin
            if (trc_valid && trc_ready) model_push(trc_n, trc_addr);
            if (req_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_op", {63'd0, req_valid}, 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("op",     64'(req_op),     64'(e.op));
                    chk("tag",    64'(req_tag),    64'(e.tag));
                    chk("index",  64'(req_index),  64'(e.index));
                    chk("offset", 64'(req_offset), 64'(e.offset));
                    chk("snoop",  64'(req_snoop),  64'(e.snoop));
                    chk("last",   64'(req_last),   64'(e.last));
                    if (req_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                        if (req_last) last_cnt++;
                        last_op = req_op; last_index = req_index; last_snoop = req_snoop;
                    end
                end
            end
        end
    end

    // Called and returning at 1 time unit after a rising edge.
    task automatic push(input logic [3:0] n, input logic [ADDR_W-1:0] a);
        int g = 0;
        trc_valid = 1'b1; trc_n = n; trc_addr = a;
        @(negedge clk);
        while (!trc_ready && g < 200) begin g++; @(negedge clk); end
        if (g >= 200) chk("push_timeout", 64'(trc_ready), 64'd1);
        @(posedge clk); #1;
        trc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 40000) begin g++; @(negedge clk); end
        chk("idle_timeout", 64'(busy), 64'd0);
        chk("model_drained", 64'(exp_q.size()), 64'd0);
        chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_illegal));
        @(posedge clk); #1;
    endtask

    initial begin
        int a0, l0, g;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(req_valid), 64'd0);
        chk("rst_op", 64'(req_op), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_illegal", 64'(illegal_cnt), 64'd0);
        rstb = 1'b1;
        @(posedge clk); #1;
        chk("rst_trc_ready", 64'(trc_ready), 64'd1);

        // Single decode, two-edge latency
        req_ready = 1'b1;
        push(4'd0, 32'h1234_5678);
        @(negedge clk);
        chk("lat_not_yet", 64'(req_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid", 64'(req_valid), 64'd1);
        chk("dec_tag", 64'(req_tag), 64'h123);
        chk("dec_index", 64'(req_index), 64'h1159);
        chk("dec_offset", 64'(req_offset), 64'h38);
        chk("dec_snoop", 64'(req_snoop), 64'd0);
        @(posedge clk); #1;
        wait_idle();

        // Backpressure: 4 in FIFO + 1 held
        req_ready = 1'b0;
        a0 = acc_cnt;
        push(4'd0, 32'hAAAA_0040);
        push(4'd1, 32'h0010_1081);
        push(4'd2, 32'hFFFF_FFFF);
        push(4'd3, 32'h0000_0000);
        push(4'd5, 32'h8000_003F);
        @(negedge clk);
        chk("bp_trc_ready", 64'(trc_ready), 64'd0);
        chk("bp_held_op", 64'(req_op), 64'd0);
        chk("bp_held_tag", 64'(req_tag), 64'hAAA);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        req_ready = 1'b1;
        wait_idle();
        chk("bp_count", 64'(acc_cnt - a0), 64'd5);

        // Illegal codes dropped
        push(4'd7, 32'h0000_1000);
        push(4'd12, 32'h0000_2000);
        push(4'd4, 32'h0000_0040);
        wait_idle();
        chk("ill_cnt_lit", 64'(illegal_cnt), 64'd2);
        chk("ill_last_op", 64'(last_op), 64'd4);
        chk("ill_last_index", 64'(last_index), 64'd1);
        chk("ill_last_snoop", 64'(last_snoop), 64'd1);

        // Clear sweep followed by a write
        a0 = acc_cnt; l0 = last_cnt;
        push(4'd8, 32'hDEAD_BEEF);
        push(4'd1, 32'h0000_00C5);
        wait_idle();
        chk("sweep_count", 64'(acc_cnt - a0), 64'(NUM_SETS + 1));
        chk("sweep_last_cnt", 64'(last_cnt - l0), 64'd1);
        chk("sweep_then_op", 64'(last_op), 64'd1);

        // Reset in the middle of a print sweep with requests queued
        push(4'd9, 32'h0);
        push(4'd0, 32'h0000_0100);
        push(4'd2, 32'h0000_0200);
        g = 0;
        @(negedge clk);
        while (!(req_valid && req_op == 4'd9 && req_index == 14'd100) && g < 1000) begin
            g++; @(negedge clk);
        end
        chk("reach_idx100", 64'(req_index), 64'd100);
        #1 rstb = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(req_valid), 64'd0);
        chk("mid_rst_op", 64'(req_op), 64'd0);
        chk("mid_rst_index", 64'(req_index), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_illegal", 64'(illegal_cnt), 64'd0);
        exp_q.delete();
        exp_illegal = 0;
        @(posedge clk); #1;
        rstb = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_trc_ready", 64'(trc_ready), 64'd1);
        wait_idle();

`ifdef CACHE_FE_STATS_EN
        push(4'd0, 32'h10);
        push(4'd0, 32'h20);
        push(4'd2, 32'h30);
        push(4'd6, 32'h40);
        push(4'd9, 32'h50);
        wait_idle();
        chk("stat_rd", 64'(rd_cnt), 64'd2);
        chk("stat_wr", 64'(wr_cnt), 64'd0);
        chk("stat_ifetch", 64'(ifetch_cnt), 64'd1);
        chk("stat_snoop", 64'(snoop_cnt), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
